instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream stage of control_unit: owns the PC, fetches one instruction per retire from instruction memory
//  over a req/rvalid handshake, and presents instr/opcode to decode. Applies the decoder's pc_src with
//  branch/jump targets to form next PC. Holds on back-pressure and traps misaligned targets.
// PARAMETERS
//  XLEN      32            datapath / PC width
//  RESET_PC  32'h0000_0000 PC loaded on reset
// PORTS
//  clk            in   1     single clock, rising edge
//  rst            in   1     asynchronous, active-high reset
//  imem_req       out  1     one-cycle fetch request pulse
//  imem_addr      out  XLEN  fetch address (= pc), stable while req/wait
//  imem_rvalid    in   1     read data valid (latency >= 1 cycle after req)
//  imem_rdata     in   32    instruction word
//  instr          out  32    held instruction
//  opcode         out  7     instr[6:0], feeds control_unit
//  pc             out  XLEN  PC of held instruction
//  pc_plus4       out  XLEN  pc + 4 (link value for JAL/JALR)
//  instr_valid    out  1     instr/pc valid for decode/execute
//  instr_ready    in   1     core retires held instruction this cycle
//  pc_src         in   2     from control_unit: 00 PC+4, 01 branch, 10 JAL/JALR, 11 reserved
//  branch_taken   in   1     branch comparison result
//  branch_target  in   XLEN  pc + B-imm
//  jump_target    in   XLEN  JAL pc+J-imm / JALR rs1+I-imm
//  fault          out  1     misaligned next-PC trap, sticky until reset
//  fault_pc       out  XLEN  offending target address
//  instret        out  64    retired-instruction counter
// BEHAVIOUR
//  FSM states: S_BOOT, S_FETCH, S_WAIT, S_VALID, S_FAULT.
//  Reset (async): state=S_BOOT, pc=RESET_PC, instr=32'h0000_0013 (NOP), fault=0, fault_pc=0, instret=0.
//   imem_req=0, instr_valid=0 during reset.
//  S_BOOT -> S_FETCH unconditionally (first req one cycle after reset release).
//  S_FETCH: imem_req=1 for exactly one cycle, imem_addr=pc; -> S_WAIT.
//  S_WAIT: on imem_rvalid, capture imem_rdata into instr; -> S_VALID. No timeout.
//  imem_rvalid outside S_WAIT is ignored (covers stale responses after reset).
//  S_VALID: instr_valid=1; instr/pc held stable until instr_ready.
//   On instr_ready, retire: instret += 1 and compute next_pc:
//    00 -> pc+4; 01 -> branch_taken ? branch_target : pc+4;
//    10 -> jump_target & ~1 (JALR LSB clear); 11 -> pc+4.
//   If next_pc[1:0] != 0: fault=1, fault_pc=next_pc, pc unchanged; -> S_FAULT.
//   Otherwise pc<=next_pc; -> S_FETCH.
//  Fetch latency: minimum 3 cycles from retire to next instr_valid (FETCH, WAIT, capture).
//  instr_ready outside S_VALID has no effect.
//  S_FAULT: terminal; instr_valid=0, imem_req=0; exit only via rst.
//  Arithmetic: all PC math modulo 2^XLEN (pc+4 wraps from 0xFFFF_FFFC to 0). instret wraps at 2^64.
//  pc_plus4 and opcode are combinational from registered pc/instr.
// STRUCTURE
//  Shared package rv_pkg: OP_* opcode constants, PC_SRC_{SEQ,BRANCH,JUMP} encodings, NOP constant,
//   fetch state enum.
//  Sub-module next_pc_sel: combinational next-PC mux plus misalignment check.
//  Top holds the FSM, PC/instr registers and instret.
// TESTING
//  1 Reset RESET_PC=0x100, mem latency 1, instr_ready=1, pc_src=00:
//    imem_addr 0x100,0x104,0x108; instret increments per retire.
//  2 pc_src=01, taken=1, target=0x200 -> next req 0x200; same with taken=0 -> pc+4.
//  3 pc_src=10, jump_target=0x301 -> fetch at 0x300, no fault.
//  4 pc_src=01, taken, target=0x202 -> fault=1, fault_pc=0x202, no further imem_req.
//  5 Hold instr_ready=0 for 5 cycles: instr/pc stable, instr_valid=1, no req, instret unchanged.
//  6 Assert rst during S_WAIT, deliver rvalid after release:
//    response ignored, first req at RESET_PC.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pkg
// Brief    : Shared RV32 fetch-stage constants, pc_src encodings and FSM states
// Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_FAULT = 3'd4
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_if
// Brief    : Instruction-memory req/rvalid bus between fetch unit and memory
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            rvalid;
  logic [31:0]     rdata;

  modport master (output req, addr, input rvalid, rdata);
  modport slave  (input req, addr, output rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/next_pc_sel.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_sel
// Brief    : Combinational next-PC mux with word-misalignment detection
// Revision : 1.0 - initial release
// ============================================================================
module next_pc_sel
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] seq_pc,
  input  logic [1:0]      pc_src,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  always_comb begin
    next_pc = seq_pc;
    case (pc_src)
      PC_SRC_BRANCH: if (branch_taken) next_pc = branch_target;
      // JALR clears bit 0; JAL targets already have it clear
      PC_SRC_JUMP:   next_pc = jump_target & ~XLEN'(1);
      default:       next_pc = seq_pc;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC owner; fetches one instruction per retire and traps bad targets
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_fetch_unit_if.master        imem,
  output logic [31:0]               instr,
  output logic [6:0]                opcode,
  output logic [XLEN-1:0]           pc,
  output logic [XLEN-1:0]           pc_plus4,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  input  logic [1:0]                pc_src,
  input  logic                      branch_taken,
  input  logic [XLEN-1:0]           branch_target,
  input  logic [XLEN-1:0]           jump_target,
  output logic                      fault,
  output logic [XLEN-1:0]           fault_pc,
  output logic [63:0]               instret
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_fault;
  logic [XLEN-1:0] r_fault_pc;
  logic [63:0]     r_instret;
  logic            w_req;
  logic            w_valid;
  logic            w_retire;
  logic            w_capture;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_next_pc;
  logic            w_misaligned;

  assign w_pc_plus4 = r_pc + XLEN'(4);

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .seq_pc        (w_pc_plus4),
    .pc_src        (pc_src),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .next_pc       (w_next_pc),
    .misaligned    (w_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_BOOT;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_valid      = 1'b0;
    w_retire     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_BOOT:  w_state_next = S_FETCH;
      S_FETCH: begin
        w_req        = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // rvalid seen in any other state is a stale response and is dropped
        if (imem.rvalid) begin
          w_capture    = 1'b1;
          w_state_next = S_VALID;
        end
      end
      S_VALID: begin
        w_valid = 1'b1;
        if (instr_ready) begin
          w_retire     = 1'b1;
          w_state_next = w_misaligned ? S_FAULT : S_FETCH;
        end
      end
      S_FAULT: w_state_next = S_FAULT;
      default: w_state_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_instr    <= NOP;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
      r_instret  <= '0;
    end else begin
      if (w_capture) r_instr <= imem.rdata;
      if (w_retire) begin
        r_instret <= r_instret + 64'd1;
        if (w_misaligned) begin
          r_fault    <= 1'b1;
          r_fault_pc <= w_next_pc;
        end else begin
          r_pc <= w_next_pc;
        end
      end
    end
  end

  assign imem.req    = w_req;
  assign imem.addr   = r_pc;
  assign instr       = r_instr;
  assign opcode      = r_instr[6:0];
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr_valid = w_valid;
  assign fault       = r_fault;
  assign fault_pc    = r_fault_pc;
  assign instret     = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed self-checking bench for instr_fetch_unit
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] jump_target = '0;
  logic        fault;
  logic [31:0] fault_pc;
  logic [63:0] instret;

  int n_assert = 0;
  int n_fail   = 0;
  int lat      = 1;
  int cnt      = 0;
  logic [31:0] pend_data = '0;

  instr_fetch_unit_if #(.XLEN(32)) imem ();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem.master),
    .instr         (instr),
    .opcode        (opcode),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc_src        (pc_src),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .fault         (fault),
    .fault_pc      (fault_pc),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[24:0], 7'h13};
  endfunction

  // Memory model: response 'lat' cycles after the request; not reset by rst
  always @(posedge clk) begin
    imem.rvalid <= 1'b0;
    if (imem.req === 1'b1) begin
      if (lat == 1) begin
        imem.rvalid <= 1'b1;
        imem.rdata  <= mem_word(imem.addr);
        cnt         <= 0;
      end else begin
        pend_data <= mem_word(imem.addr);
        cnt       <= lat - 1;
      end
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        imem.rvalid <= 1'b1;
        imem.rdata  <= pend_data;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic [31:0] exp_addr, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (imem.req !== 1'b1 && n < 30);
    chk({tag, "_req"}, 64'(imem.req), 64'd1);
    chk({tag, "_addr"}, 64'(imem.addr), 64'(exp_addr));
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (instr_valid !== 1'b1 && n < 30);
    chk({tag, "_valid"}, 64'(instr_valid), 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, 64'(pc), 64'h100);
    chk({tag, "_instr"}, 64'(instr), 64'h13);
    chk({tag, "_valid"}, 64'(instr_valid), 64'd0);
    chk({tag, "_req"}, 64'(imem.req), 64'd0);
    chk({tag, "_fault"}, 64'(fault), 64'd0);
    chk({tag, "_fault_pc"}, 64'(fault_pc), 64'd0);
    chk({tag, "_instret"}, instret, 64'd0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check_reset_state("rst0");
    @(negedge clk);
    rst = 1'b0;

    // 1: sequential fetch with ready held high
    instr_ready = 1'b1;
    wait_req(32'h100, "seq0");
    @(negedge clk);
    chk("seq0_req_one_cycle", 64'(imem.req), 64'd0);
    wait_valid("seq0");
    chk("seq0_instr", 64'(instr), 64'h0000_8013);
    chk("seq0_opcode", 64'(opcode), 64'h13);
    chk("seq0_pc", 64'(pc), 64'h100);
    chk("seq0_pc_plus4", 64'(pc_plus4), 64'h104);
    chk("seq0_instret", instret, 64'd0);
    wait_req(32'h104, "seq1");
    chk("seq1_instret", instret, 64'd1);
    wait_req(32'h108, "seq2");
    chk("seq2_instret", instret, 64'd2);
    instr_ready = 1'b0;

    // 5: hold ready low for five cycles
    wait_valid("hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(instr_valid), 64'd1);
      chk("hold_req", 64'(imem.req), 64'd0);
      chk("hold_instr", 64'(instr), 64'h0000_8413);
      chk("hold_pc", 64'(pc), 64'h108);
      chk("hold_instret", instret, 64'd2);
    end

    // 2: taken branch then not-taken branch
    pc_src = 2'b01; branch_taken = 1'b1; branch_target = 32'h200; instr_ready = 1'b1;
    wait_req(32'h200, "br_taken");
    instr_ready = 1'b0;
    wait_valid("br_taken");
    chk("br_taken_instr", 64'(instr), 64'h0001_0013);
    chk("br_taken_instret", instret, 64'd3);
    pc_src = 2'b01; branch_taken = 1'b0; branch_target = 32'h400; instr_ready = 1'b1;
    wait_req(32'h204, "br_not");
    instr_ready = 1'b0;
    wait_valid("br_not");

    // 3: JALR-style target with bit 0 set
    pc_src = 2'b10; jump_target = 32'h301; instr_ready = 1'b1;
    wait_req(32'h300, "jump");
    instr_ready = 1'b0;
    chk("jump_fault", 64'(fault), 64'd0);
    wait_valid("jump");
    chk("jump_instr", 64'(instr), 64'h0001_8013);
    chk("jump_pc_plus4", 64'(pc_plus4), 64'h304);

    // 4: misaligned branch target traps
    pc_src = 2'b01; branch_taken = 1'b1; branch_target = 32'h202; instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("fault_flag", 64'(fault), 64'd1);
    chk("fault_pc", 64'(fault_pc), 64'h202);
    chk("fault_pc_held", 64'(pc), 64'h300);
    chk("fault_instret", instret, 64'd6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("fault_no_req", 64'(imem.req), 64'd0);
      chk("fault_no_valid", 64'(instr_valid), 64'd0);
    end

    // 6: reset during WAIT, stale response arrives after release
    pc_src = 2'b00; branch_taken = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("rst1");
    rst = 1'b0;
    wait_req(32'h100, "r6a");
    wait_valid("r6a");
    lat = 3;
    instr_ready = 1'b1;
    wait_req(32'h104, "r6b");
    instr_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_req(32'h100, "r6_after");
    lat = 1;
    wait_valid("r6_after");
    chk("r6_instr", 64'(instr), 64'h0000_8013);
    chk("r6_pc", 64'(pc), 64'h100);
    chk("r6_instret", instret, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
